// File: rtl/addsub_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_accum_pipe
// Purpose  : Registered adder / subtractor / accumulator with valid/ready
//            handshakes on both sides, optional unsigned saturation and
//            carry / signed-overflow / zero flags. One-cycle latency, full
//            throughput, single output register stage.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready, in_a, in_b, in_cin, in_mode (00 ADD, 01 SUB,
//            10 ACC, 11 CLR)
//            out_valid/out_ready, out_sum, out_cout, out_ovf, out_zero
//            acc_value, acc_sticky
// Revision : 1.0 - initial release
// ============================================================================
module addsub_accum_pipe #(
    parameter int WIDTH    = 6,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc_value,
    output logic             acc_sticky
);

    localparam logic [1:0] c_MODE_ADD = 2'b00;
    localparam logic [1:0] c_MODE_SUB = 2'b01;
    localparam logic [1:0] c_MODE_ACC = 2'b10;
    localparam logic [1:0] c_MODE_CLR = 2'b11;

    // Output register occupancy is the only state machine.
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;

    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_cin;
    logic [WIDTH:0]   w_raw;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    assign out_valid  = (r_state == c_FULL);
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign out_sum    = r_sum;
    assign out_cout   = r_cout;
    assign out_ovf    = r_ovf;
    assign out_zero   = r_zero;
    assign acc_value  = r_acc;
    assign acc_sticky = r_sticky;

    // Operand selection. CLR feeds zeros with no carry-in, so the shared
    // adder naturally yields result 0, cout 0, ovf 0.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        w_cin  = in_cin;
        case (in_mode)
            c_MODE_ADD: begin
                w_op_a = in_a;
                w_op_b = in_b;
            end
            c_MODE_SUB: begin
                w_op_a = in_a;
                w_op_b = ~in_b;
            end
            c_MODE_ACC: begin
                w_op_a = r_acc;
                w_op_b = in_a;
            end
            default: begin
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_raw  = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_cout = w_raw[WIDTH];
    assign w_ovf  = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) &&
                    (w_raw[WIDTH-1] != w_op_a[WIDTH-1]);

    // Saturation clamps the result only; flags keep the raw carry.
    always_comb begin
        w_result = w_raw[WIDTH-1:0];
        if (SATURATE) begin
            if (((in_mode == c_MODE_ADD) || (in_mode == c_MODE_ACC)) && w_cout) begin
                w_result = '1;
            end else if ((in_mode == c_MODE_SUB) && !w_cout) begin
                w_result = '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = c_FULL;
        end else if (out_ready) begin
            w_state_nxt = c_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_EMPTY;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sum  <= w_result;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_result == '0);
                if (in_mode == c_MODE_ACC) begin
                    r_acc    <= w_result;
                    r_sticky <= r_sticky | w_cout;
                end else if (in_mode == c_MODE_CLR) begin
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_accum_pipe
// Purpose  : Self-checking bench for addsub_accum_pipe. Two instances
//            (wrapping and saturating, WIDTH=6) share one stimulus stream;
//            an arithmetic model pushes expected results to per-instance
//            queues on each accepted beat, popped when the output is taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_accum_pipe;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [1:0]   in_mode;
    logic         out_ready;

    logic         in_ready   [2];
    logic         out_valid  [2];
    logic [W-1:0] out_sum    [2];
    logic         out_cout   [2];
    logic         out_ovf    [2];
    logic         out_zero   [2];
    logic [W-1:0] acc_value  [2];
    logic         acc_sticky [2];

    int vectors     = 0;
    int miscompares = 0;

    res_t         q0[$];
    res_t         q1[$];
    bit           m_valid;
    logic [W-1:0] m_acc    [2];
    logic         m_sticky [2];

    always #5 clk = ~clk;

    addsub_accum_pipe #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_sum(out_sum[0]), .out_cout(out_cout[0]), .out_ovf(out_ovf[0]),
        .out_zero(out_zero[0]), .acc_value(acc_value[0]), .acc_sticky(acc_sticky[0])
    );

    addsub_accum_pipe #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_sum(out_sum[1]), .out_cout(out_cout[1]), .out_ovf(out_ovf[1]),
        .out_zero(out_zero[1]), .acc_value(acc_value[1]), .acc_sticky(acc_sticky[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    // Integer reference model of the arithmetic.
    function automatic res_t model(input bit sat, input logic [1:0] mode, input int a, input int b,
                                   input int cin, input int acc);
        res_t r;
        int   x, y, raw, sx, sy, s;
        x = 0; y = 0;
        case (mode)
            2'b00: begin x = a;   y = b;      end
            2'b01: begin x = a;   y = 63 - b; end
            2'b10: begin x = acc; y = a;      end
            default: begin x = 0; y = 0; cin = 0; end
        endcase
        raw    = x + y + cin;
        sx     = (x >= 32) ? x - 64 : x;
        sy     = (y >= 32) ? y - 64 : y;
        s      = sx + sy + cin;
        r.cout = (raw >= 64);
        r.ovf  = (s > 31) || (s < -32);
        r.sum  = W'(raw % 64);
        if (sat && (mode == 2'b00 || mode == 2'b10) && r.cout) r.sum = 6'd63;
        if (sat && (mode == 2'b01) && !r.cout) r.sum = 6'd0;
        r.zero = (r.sum == 0);
        return r;
    endfunction

    // One clock: check at negedge, advance model, return whether a beat was accepted.
    task automatic cycle(output bit accepted);
        bit   rdy;
        res_t e;
        @(negedge clk);
        rdy = !m_valid || out_ready;
        for (int d = 0; d < 2; d++) begin
            chk("in_ready",   d, 32'(in_ready[d]),   32'(rdy));
            chk("out_valid",  d, 32'(out_valid[d]),  32'(m_valid));
            chk("acc_value",  d, 32'(acc_value[d]),  32'(m_acc[d]));
            chk("acc_sticky", d, 32'(acc_sticky[d]), 32'(m_sticky[d]));
            if (m_valid) begin
                e = (d == 0) ? q0[0] : q1[0];
                chk("out_sum",  d, 32'(out_sum[d]),  32'(e.sum));
                chk("out_cout", d, 32'(out_cout[d]), 32'(e.cout));
                chk("out_ovf",  d, 32'(out_ovf[d]),  32'(e.ovf));
                chk("out_zero", d, 32'(out_zero[d]), 32'(e.zero));
            end
        end
        accepted = 1'b0;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin m_acc[d] = '0; m_sticky[d] = 1'b0; end
        end else begin
            accepted = in_valid && rdy;
            if (m_valid && out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (accepted) begin
                for (int d = 0; d < 2; d++) begin
                    e = model(d == 1, in_mode, int'(in_a), int'(in_b), int'(in_cin), int'(m_acc[d]));
                    if (d == 0) q0.push_back(e); else q1.push_back(e);
                    if (in_mode == 2'b10) begin
                        m_acc[d]    = e.sum;
                        m_sticky[d] = m_sticky[d] | e.cout;
                    end else if (in_mode == 2'b11) begin
                        m_acc[d]    = '0;
                        m_sticky[d] = 1'b0;
                    end
                end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one beat, holding it until it is accepted (bounded).
    task automatic beat(input logic [1:0] mode, input int a, input int b, input bit cin);
        bit acc_f;
        int n;
        in_valid = 1'b1; in_mode = mode; in_a = W'(a); in_b = W'(b); in_cin = cin;
        n = 0;
        do begin
            cycle(acc_f);
            n++;
        end while (!acc_f && n < 20);
        if (!acc_f) begin
            vectors++; miscompares++;
            $error("FAIL beat_accept_timeout: observed not-accepted expected accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc_f;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc_f);
    endtask

    initial begin
        bit acc_f;
        int got;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_mode = 2'b00; out_ready = 1'b1;
        m_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin m_acc[d] = '0; m_sticky[d] = 1'b0; end
        @(posedge clk); #1;
        cycle(acc_f);
        cycle(acc_f);
        rst_n = 1'b1;

        // Reset state of the result register
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_sum",  d, 32'(out_sum[d]),  32'd0);
            chk("rst_out_cout", d, 32'(out_cout[d]), 32'd0);
            chk("rst_out_ovf",  d, 32'(out_ovf[d]),  32'd0);
            chk("rst_out_zero", d, 32'(out_zero[d]), 32'd0);
        end
        @(posedge clk); #1;

        // Directed arithmetic cases
        beat(2'b00, 63, 1, 1'b0);   // wrap to zero, carry
        idle(1);
        beat(2'b00, 31, 1, 1'b0);   // signed overflow
        idle(1);
        beat(2'b01, 5, 7, 1'b1);    // borrow; saturating instance clamps to 0
        beat(2'b01, 9, 4, 1'b1);    // back-to-back, no borrow
        idle(1);
        beat(2'b11, 0, 0, 1'b0);
        beat(2'b10, 40, 0, 1'b0);
        beat(2'b10, 30, 0, 1'b0);   // acc 6 (sat 63), sticky set
        idle(1);
        beat(2'b11, 0, 0, 1'b0);    // clears acc and sticky
        idle(1);
        beat(2'b00, 20, 12, 1'b1);
        idle(1);

        // Stall: stream with out_ready low for 3 cycles
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12 && got < 6; i++) begin
            in_valid  = 1'b1;
            in_mode   = 2'(got % 3);
            in_a      = W'(7 * got + 11);
            in_b      = W'(5 * got + 3);
            in_cin    = got[0];
            out_ready = !(i >= 1 && i <= 3);
            cycle(acc_f);
            if (acc_f) got++;
        end
        vectors++;
        assert (got == 6) else begin
            miscompares++;
            $error("FAIL stall_stream_beats: observed %0d expected %0d", got, 6);
        end
        out_ready = 1'b1;
        idle(2);

        // Reset while holding a result with acc = 17, sticky = 1
        beat(2'b11, 0, 0, 1'b0);
        beat(2'b10, 50, 0, 1'b0);
        beat(2'b10, 31, 0, 1'b0);
        out_ready = 1'b0;
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_out_valid",  d, 32'(out_valid[d]),  32'd0);
            chk("post_rst_acc_value",  d, 32'(acc_value[d]),  32'd0);
            chk("post_rst_acc_sticky", d, 32'(acc_sticky[d]), 32'd0);
            chk("post_rst_in_ready",   d, 32'(in_ready[d]),   32'd1);
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!m_valid || out_ready) begin
                in_mode = 2'($urandom_range(0, 3));
                in_a    = W'($urandom_range(0, 63));
                in_b    = W'($urandom_range(0, 63));
                in_cin  = 1'($urandom_range(0, 1));
            end
            cycle(acc_f);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        vectors++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d/%0d entries expected 0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
